// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings and pipeline-depth limits for the pipelined logic unit.
package logic_unit_pkg;

  localparam logic [2:0] FN_AND  = 3'b000;
  localparam logic [2:0] FN_OR   = 3'b001;
  localparam logic [2:0] FN_NAND = 3'b010;
  localparam logic [2:0] FN_NOR  = 3'b011;
  localparam logic [2:0] FN_XOR  = 3'b100;
  localparam logic [2:0] FN_XNOR = 3'b101;
  localparam logic [2:0] FN_ANDN = 3'b110;
  localparam logic [2:0] FN_NOT  = 3'b111;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  function automatic bit stages_ok(input int s);
    return (s >= STAGES_MIN) && (s <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid-tagged register slot of the logic-unit pipeline; refills whenever empty or draining.
module logic_pipe_stage #(
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_vld,
  input  logic [DATA_W-1:0] pred_data,
  input  logic              succ_ready,
  output logic              vld,
  output logic [DATA_W-1:0] data,
  output logic              ready
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A full slot can take new content in the same cycle its own content moves on.
  assign ready = ~vld_q | succ_ready;
  assign vld   = vld_q;
  assign data  = data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (ready) begin
      vld_d = pred_vld;
      if (pred_vld) data_d = pred_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined eight-op bitwise logic unit with zero flag, bubble-collapsing stages and
// ready/valid handshakes on both sides.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func,
  input  logic             out_ready,
  output logic             logic_flag,
  output logic [WIDTH-1:0] logic_out,
  output logic             logic_zero
);

  generate
    if (!stages_ok(STAGES)) begin : g_bad_stages
      $error("logic_unit_pipe: STAGES out of range");
    end
  endgenerate

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (f)
      FN_AND:  r = x & y;
      FN_OR:   r = x | y;
      FN_NAND: r = ~(x & y);
      FN_NOR:  r = ~(x | y);
      FN_XOR:  r = x ^ y;
      FN_XNOR: r = ~(x ^ y);
      FN_ANDN: r = x & ~y;
      default: r = ~x;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] res_p0;
  logic [STAGES:0]  vld_p;
  logic [STAGES:0]  ready_p;
  logic [WIDTH:0]   data_p [STAGES+1];

  // Stage-0 input: result and its zero flag packed as one word.
  assign res_p0          = logic_op(func, a, b);
  assign data_p[0]       = {~|res_p0, res_p0};
  assign vld_p[0]        = enable & rst;
  assign ready_p[STAGES] = out_ready;

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic_pipe_stage #(
        .DATA_W (WIDTH + 1)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .pred_vld   (vld_p[i]),
        .pred_data  (data_p[i]),
        .succ_ready (ready_p[i+1]),
        .vld        (vld_p[i+1]),
        .data       (data_p[i+1]),
        .ready      (ready_p[i])
      );
    end
  endgenerate

  // Output side: nothing is offered while reset is asserted.
  assign in_ready   = rst & ready_p[0];
  assign logic_flag = rst & vld_p[STAGES];
  assign logic_out  = logic_flag ? data_p[STAGES][WIDTH-1:0] : '0;
  assign logic_zero = logic_flag & data_p[STAGES][WIDTH];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus random traffic against a
// queue-based transaction model.
module tb_logic_unit_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       func;
  logic             out_ready;
  logic             logic_flag;
  logic [WIDTH-1:0] logic_out;
  logic             logic_zero;

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .func       (func),
    .out_ready  (out_ready),
    .logic_flag (logic_flag),
    .logic_out  (logic_out),
    .logic_zero (logic_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               acc;
  } ent_t;

  ent_t             q[$];
  logic [WIDTH-1:0] seen[$];
  int               seen_cyc[$];
  int               cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] f,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (f)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~(x & y);
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return ~x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic ordy, input logic [2:0] f,
                       input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       output bit acc);
    bit               exp_ready, vis;
    logic [WIDTH-1:0] exp_out;
    rst = r; enable = en; out_ready = ordy; func = f; a = av; b = bv;
    #1;
    exp_ready = r && ((q.size() < STAGES) || ordy);
    vis       = r && (q.size() > 0) && ((cyc - q[0].acc) >= STAGES - 1);
    exp_out   = vis ? q[0].res : '0;
    chk("in_ready",   32'(in_ready),   32'(exp_ready));
    chk("logic_flag", 32'(logic_flag), 32'(vis));
    chk("logic_out",  32'(logic_out),  32'(exp_out));
    chk("logic_zero", 32'(logic_zero), 32'(vis && (exp_out == '0)));
    if (vis && ordy) begin
      seen.push_back(logic_out);
      seen_cyc.push_back(cyc);
    end
    acc = en && exp_ready;
    @(posedge clk);
    cyc++;
    if (!r) q.delete();
    else begin
      if (vis && ordy) void'(q.pop_front());
      if (acc) q.push_back('{ref_op(f, av, bv), cyc});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, ordy, 3'd0, '0, '0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               acc;
    int               tries;
    logic [WIDTH-1:0] sweep_exp [8];
    logic [WIDTH-1:0] bp_exp [3];
    logic [2:0]       bp_fn [3];
    sweep_exp = '{16'hF000, 16'hFFF0, 16'h0FFF, 16'h000F,
                  16'h0FF0, 16'hF00F, 16'h00F0, 16'h0F0F};

    // Reset held with live traffic on the inputs.
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom), acc);

    // Opcode sweep.
    seen.delete();
    for (int f = 0; f < 8; f++) cycle(1'b1, 1'b1, 1'b1, 3'(f), 16'hF0F0, 16'hFF00, acc);
    idle(3, 1'b1);
    chk("sweep_count", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("sweep_value", 32'(seen[i]), 32'(sweep_exp[i]));

    // Zero flag.
    seen.delete();
    cycle(1'b1, 1'b1, 1'b1, 3'd4, 16'h1234, 16'h1234, acc);
    idle(3, 1'b1);
    chk("zero_count", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) chk("zero_value", 32'(seen[0]), 32'd0);

    // Backpressure: two fit, the third is held until release.
    seen.delete();
    bp_fn = '{3'd0, 3'd4, 3'd7};
    for (int i = 0; i < 3; i++) bp_exp[i] = ref_op(bp_fn[i], 16'hA5C3, 16'h0FF0);
    cycle(1'b1, 1'b1, 1'b0, bp_fn[0], 16'hA5C3, 16'h0FF0, acc);
    cycle(1'b1, 1'b1, 1'b0, bp_fn[1], 16'hA5C3, 16'h0FF0, acc);
    cycle(1'b1, 1'b1, 1'b0, bp_fn[2], 16'hA5C3, 16'h0FF0, acc);
    idle(2, 1'b0);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 4) begin
      cycle(1'b1, 1'b1, 1'b1, bp_fn[2], 16'hA5C3, 16'h0FF0, acc);
      tries++;
    end
    chk("bp_release_accept_tries", 32'(tries), 32'd1);
    idle(4, 1'b1);
    chk("bp_count", 32'(seen.size()), 32'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("bp_order", 32'(seen[i]), 32'(bp_exp[i]));

    // Bubble collapse.
    seen.delete();
    seen_cyc.delete();
    cycle(1'b1, 1'b1, 1'b0, 3'd1, 16'h1111, 16'h2222, acc);
    idle(1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 3'd6, 16'hFFFF, 16'h00FF, acc);
    idle(2, 1'b0);
    idle(4, 1'b1);
    chk("bubble_count", 32'(seen.size()), 32'd2);
    if (seen_cyc.size() == 2) chk("bubble_consecutive", 32'(seen_cyc[1] - seen_cyc[0]), 32'd1);

    // Random traffic.
    for (int i = 0; i < 1000; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom), acc);

    // Reset in the middle of a stall.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), acc);
    cycle(1'b0, 1'b1, 1'b1, 3'd0, 16'hFFFF, 16'hFFFF, acc);
    idle(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
